fb_serializer: RTL

Downstream consumer of the 4-bit load register. It takes the register's parallel output word through a VALID/READY handshake and shifts it out as a framed serial bit stream: start bit, data LSB-first, optional parity, stop bit. Each bit is held for a programmable number of clocks. It reports BUSY while a frame is in flight and pulses DONE for one cycle at frame end.

---
 rtl/fb_serializer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/fb_serializer.sv
// -----------------------------------------------------------------------------
// fb_serializer
//
// Takes a parallel word from the upstream load register over a VALID/READY
// handshake and transmits it as a framed serial stream:
//   start bit (0), WIDTH data bits LSB-first, optional parity bit, stop bit (1).
// Every bit is held for CLKS_PER_BIT clocks. All outputs are registered.
//
// Ports:
//   CLK    in   1      system clock, rising edge
//   RST    in   1      asynchronous active-high reset
//   D      in   WIDTH  parallel word to transmit
//   VALID  in   1      D holds a word to transmit
//   READY  out  1      a word is accepted on an edge where VALID and READY
//   TX     out  1      serial output, idles high
//   BUSY   out  1      frame in progress
//   DONE   out  1      one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module fb_serializer #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic             READY,
  output logic             TX,
  output logic             BUSY,
  output logic             DONE
);

  // Counter widths hold CLKS_PER_BIT-1 and WIDTH-1; at least one bit each.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);

  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic PAR_EN_BIT  = (PARITY_EN != 0) ? 1'b1 : 1'b0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity of a word, inverted for odd parity.
  function automatic logic calc_parity(input logic [WIDTH-1:0] word, input logic odd);
    calc_parity = (^word) ^ odd;
  endfunction

  logic [2:0]       state_r, state_s;
  logic [CW-1:0]    clk_cnt_r, clk_cnt_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic             par_r, par_s;
  logic             tx_r, tx_s;
  logic             busy_r, busy_s;
  logic             ready_r, ready_s;
  logic             done_r, done_s;
  logic             bit_end_s;

  assign READY = ready_r;
  assign TX    = tx_r;
  assign BUSY  = busy_r;
  assign DONE  = done_r;

  // Last clock of the current serial bit.
  always_comb begin
    if (clk_cnt_r == CNT_LAST) begin
      bit_end_s = 1'b1;
    end else begin
      bit_end_s = 1'b0;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that TX/BUSY/READY/DONE all come straight from flops.
  always_comb begin
    state_s   = state_r;
    clk_cnt_s = clk_cnt_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    par_s     = par_r;
    tx_s      = tx_r;
    busy_s    = busy_r;
    ready_s   = ready_r;
    done_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        ready_s = 1'b1;
        if (VALID && ready_r) begin
          // Capture the word and its parity; later changes on D are ignored.
          shift_s   = D;
          par_s     = calc_parity(D, PAR_ODD_BIT);
          state_s   = ST_START;
          clk_cnt_s = CNT_ZERO;
          bit_cnt_s = BIT_ZERO;
          tx_s      = 1'b0;
          busy_s    = 1'b1;
          ready_s   = 1'b0;
        end else begin
          clk_cnt_s = CNT_ZERO;
          bit_cnt_s = BIT_ZERO;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          clk_cnt_s = CNT_ZERO;
          state_s   = ST_DATA;
          tx_s      = shift_r[0];
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          clk_cnt_s = CNT_ZERO;
          shift_s   = shift_r >> 1;
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_s = BIT_ZERO;
            if (PAR_EN_BIT) begin
              state_s = ST_PARITY;
              tx_s    = par_r;
            end else begin
              state_s = ST_STOP;
              tx_s    = 1'b1;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
            // Next data bit is the new LSB after the shift.
            tx_s      = shift_s[0];
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end

      ST_PARITY: begin
        if (bit_end_s) begin
          clk_cnt_s = CNT_ZERO;
          state_s   = ST_STOP;
          tx_s      = 1'b1;
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (bit_end_s) begin
          clk_cnt_s = CNT_ZERO;
          state_s   = ST_IDLE;
          tx_s      = 1'b1;
          busy_s    = 1'b0;
          ready_s   = 1'b1;
          done_s    = 1'b1;
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle line.
        state_s   = ST_IDLE;
        clk_cnt_s = CNT_ZERO;
        bit_cnt_s = BIT_ZERO;
        tx_s      = 1'b1;
        busy_s    = 1'b0;
        ready_s   = 1'b1;
        done_s    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a DONE pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      clk_cnt_r <= CNT_ZERO;
      bit_cnt_r <= BIT_ZERO;
      shift_r   <= {WIDTH{1'b0}};
      par_r     <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      clk_cnt_r <= clk_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      par_r     <= par_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      ready_r   <= ready_s;
      done_r    <= done_s;
    end
  end

endmodule
